// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf;

   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, WIDTH cycles.
// Optional signed-overflow flag ovf is compiled in with SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_subtractor_if.slave bus
);
   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] diff_r;
   logic [CNT_W-1:0] cnt_r;
   logic             br_r;
   logic             bout_r;
   logic             busy_r;
   logic             done_r;
   logic             load_s;
   logic             shift_s;
   logic             finish_s;
   logic             d_s;
   logic             br_nx_s;

   // Full-subtractor cell: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bi);
      sub_bit = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
   endfunction

   assign {br_nx_s, d_s} = sub_bit(a_r[0], b_r[0], br_r);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and datapath control; start is only honoured in IDLE or DONE.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      finish_s   = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (bus.start) begin
               load_s     = 1'b1;
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            shift_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
               finish_s   = 1'b1;
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Operand shift registers, borrow, bit counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         res_r  <= {WIDTH{1'b0}};
         diff_r <= {WIDTH{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         br_r   <= 1'b0;
         bout_r <= 1'b0;
      end else if (load_s) begin
         a_r   <= bus.a;
         b_r   <= bus.b;
         br_r  <= bus.bin;
         cnt_r <= {CNT_W{1'b0}};
      end else if (shift_s) begin
         a_r   <= {1'b0, a_r[WIDTH-1:1]};
         b_r   <= {1'b0, b_r[WIDTH-1:1]};
         res_r <= {d_s, res_r[WIDTH-1:1]};
         br_r  <= br_nx_s;
         // Counter returns to 0 on the last bit so it never exceeds WIDTH-1.
         cnt_r <= finish_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
         if (finish_s) begin
            diff_r <= {d_s, res_r[WIDTH-1:1]};
            bout_r <= br_nx_s;
         end
      end
   end

   // Handshake outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic ovf_r;

   // Signed overflow: borrow into the MSB stage differs from borrow out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (finish_s) begin
         ovf_r <= br_r ^ br_nx_s;
      end
   end

   assign bus.ovf = ovf_r;
`endif

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks for serial_subtractor at WIDTH=8.
// ovf checks are active when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents operands and returns just after the accepting edge.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
      sif.a     = a;
      sif.b     = b;
      sif.bin   = bin;
      sif.start = 1'b1;
      @(posedge clk);
      #1 sif.start = 1'b0;
   endtask

   // Counts edges until done is seen at a negedge (bounded); returns at that negedge.
   task automatic wait_done(output int edges, output int busy_n, output int excl_bad);
      edges    = 0;
      busy_n   = 0;
      excl_bad = 0;
      while (1) begin
         @(negedge clk);
         if (sif.busy && sif.done) excl_bad++;
         if (sif.done) break;
         if (sif.busy) busy_n++;
         if (edges >= 20) break;
         @(posedge clk);
         edges++;
      end
   endtask

   task automatic chk_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic bin);
      logic [7:0] exp_diff;
      logic       exp_bout;
      exp_diff = a - b - {7'd0, bin};
      exp_bout = ({1'b0, a} < ({1'b0, b} + {8'd0, bin}));
      chk({tag, "_done"}, {31'd0, sif.done}, 32'd1);
      chk({tag, "_diff"}, {24'd0, sif.diff}, {24'd0, exp_diff});
      chk({tag, "_bout"}, {31'd0, sif.bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUB_OVERFLOW_EN
      begin
         int  r;
         logic exp_ovf;
         r       = int'($signed(a)) - int'($signed(b)) - int'(bin);
         exp_ovf = (r < -128) || (r > 127);
         chk({tag, "_ovf"}, {31'd0, sif.ovf}, {31'd0, exp_ovf});
      end
`endif
   endtask

   initial begin
      int edges;
      int busy_n;
      int excl;
      int done_cnt;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;

      rst       = 1'b1;
      sif.start = 1'b0;
      sif.a     = 8'd0;
      sif.b     = 8'd0;
      sif.bin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, sif.busy}, 32'd0);
      chk("rst_done", {31'd0, sif.done}, 32'd0);
      chk("rst_diff", {24'd0, sif.diff}, 32'd0);
      chk("rst_bout", {31'd0, sif.bout}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("rst_ovf", {31'd0, sif.ovf}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // 100 - 58: latency and busy length
      launch(8'd100, 8'd58, 1'b0);
      wait_done(edges, busy_n, excl);
      chk("t1_latency", edges, 32'd8);
      chk("t1_busy_cycles", busy_n, 32'd8);
      chk("t1_excl", excl, 32'd0);
      chk("t1_diff_const", {24'd0, sif.diff}, 32'd42);
      chk_result("t1", 8'd100, 8'd58, 1'b0);
      @(negedge clk);
      chk("t1_done_pulse", {31'd0, sif.done}, 32'd0);
      chk("t1_idle_busy", {31'd0, sif.busy}, 32'd0);
      chk("t1_diff_hold", {24'd0, sif.diff}, 32'd42);

      // 0 - 1 wraps
      launch(8'h00, 8'h01, 1'b0);
      wait_done(edges, busy_n, excl);
      chk("t2_diff_const", {24'd0, sif.diff}, 32'hFF);
      chk("t2_bout_const", {31'd0, sif.bout}, 32'd1);
      chk_result("t2", 8'h00, 8'h01, 1'b0);
      @(negedge clk);

      // 5 - 5 - 1, then 0x80 - 1 signed overflow
      launch(8'h05, 8'h05, 1'b1);
      wait_done(edges, busy_n, excl);
      chk("t3_diff_const", {24'd0, sif.diff}, 32'hFF);
      chk("t3_bout_const", {31'd0, sif.bout}, 32'd1);
      chk_result("t3", 8'h05, 8'h05, 1'b1);
      @(negedge clk);
      launch(8'h80, 8'h01, 1'b0);
      wait_done(edges, busy_n, excl);
      chk("t4_diff_const", {24'd0, sif.diff}, 32'h7F);
      chk("t4_bout_const", {31'd0, sif.bout}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("t4_ovf_const", {31'd0, sif.ovf}, 32'd1);
`endif
      chk_result("t4", 8'h80, 8'h01, 1'b0);
      @(negedge clk);

      // start during RUN is ignored
      launch(8'hF0, 8'h0F, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      launch(8'h11, 8'h22, 1'b1);
      wait_done(edges, busy_n, excl);
      chk("t5_remaining_edges", edges, 32'd5);
      chk("t5_diff_const", {24'd0, sif.diff}, 32'hE1);
      chk_result("t5", 8'hF0, 8'h0F, 1'b0);
      @(negedge clk);
      chk("t5_no_second_op", {31'd0, sif.busy}, 32'd0);

      // reset on the 4th RUN cycle aborts the operation
      launch(8'h3C, 8'h10, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_busy", {31'd0, sif.busy}, 32'd0);
      chk("t6_done", {31'd0, sif.done}, 32'd0);
      chk("t6_diff", {24'd0, sif.diff}, 32'd0);
      chk("t6_bout", {31'd0, sif.bout}, 32'd0);
      rst = 1'b0;
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (sif.done || sif.busy) done_cnt++;
      end
      chk("t6_no_done", done_cnt, 32'd0);
      launch(8'd3, 8'd1, 1'b0);
      wait_done(edges, busy_n, excl);
      chk("t6_latency", edges, 32'd8);
      chk("t6_diff_const", {24'd0, sif.diff}, 32'd2);
      chk_result("t6", 8'd3, 8'd1, 1'b0);
      @(negedge clk);

      // rst and start on the same edge: start dropped
      sif.start = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      chk("t7_rst_wins_busy", {31'd0, sif.busy}, 32'd0);
      @(negedge clk);
      chk("t7_rst_wins_idle", {31'd0, sif.busy}, 32'd0);

      // 1000 random operations, back-to-back via start in DONE
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      launch(ra, rb, rbin);
      wait_done(edges, busy_n, excl);
      chk_result("rnd_first", ra, rb, rbin);
      for (int i = 1; i < 1000; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         launch(ra, rb, rbin);
         wait_done(edges, busy_n, excl);
         chk("rnd_done_interval", edges + 1, 32'd9);
         chk("rnd_excl", excl, 32'd0);
         chk_result("rnd", ra, rb, rbin);
      end
      @(negedge clk);
      chk("rnd_final_idle", {31'd0, sif.done | sif.busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - bin` over WIDTH clock cycles, LSB first, with a single borrow flip-flop. It is the inverse counterpart of the team's carry/lookahead adders. It sits behind the same operand interface, and its results are checked against them: `a == diff + b + bin` modulo 2^WIDTH, with `bout` mirroring carry-out. A start/busy/done handshake sequences one operation at a time.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range WIDTH >= 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a subtraction; sampled only when the block can accept.
- `a` input WIDTH: minuend; captured on the accepted `start` edge.
- `b` input WIDTH: subtrahend; captured on the accepted `start` edge.
- `bin` input 1: borrow-in; captured on the accepted `start` edge.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse when `diff`/`bout` become valid.
- `diff` output WIDTH: difference; holds its value until the next accepted `start`.
- `bout` output 1: borrow-out of the MSB; 1 means unsigned `a < b + bin`.
- `ovf` output 1: signed overflow; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE with `start`=1:
  - load shift registers A<=a and B<=b;
  - load borrow register br<=bin;
  - clear bit counter cnt<=0;
  - go to RUN.
- RUN, on each edge:
  - compute `d = A[0]^B[0]^br`;
  - compute `br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&br)`;
  - shift A and B right one bit;
  - shift d into the MSB of the result register;
  - cnt <= cnt+1.
- RUN exit: on the edge where cnt == WIDTH-1, go to DONE. The final result register becomes `diff` and the final br becomes `bout`.
- DONE: `done`=1 for exactly one cycle.
  - Next state is IDLE.
  - If `start`=1 in DONE, it is accepted as in IDLE and the next state is RUN instead (back-to-back operation).
- `start` in RUN is ignored; no queuing.
- `diff` and `bout` change only on the RUN-to-DONE edge. They are stable from that point until the next RUN-to-DONE edge.
- Arithmetic is modulo 2^WIDTH. Wrap-around is defined behaviour and is reported only through `bout` (and `ovf` when compiled in).
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0. Internal state: IDLE, cnt=0, br=0.
- Edge E0 accepts `start`; `busy`=1 during the cycles after edges E0 through E(WIDTH-1).
- Edge E(WIDTH) enters DONE: `busy`=0 and `done`=1 in that cycle. Latency from accepted start to done is WIDTH edges.
- Minimum issue interval is WIDTH+1 cycles, achieved with `start` asserted in the DONE cycle.
- `rst` during RUN or DONE:
  - next state is IDLE;
  - all outputs return to reset values;
  - no `done` pulse for the aborted operation.
- `rst` and `start` on the same edge: `rst` wins and `start` is dropped.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - port `ovf` exists;
  - `ovf` is registered on the RUN-to-DONE edge as (borrow into the MSB stage) XOR `bout`, i.e. the signed result is not representable in WIDTH bits;
  - `ovf` holds with `diff` and resets to 0.
- Undefined: port `ovf` and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- a=100, b=58, bin=0, start pulsed -> `done` exactly 8 cycles later; `diff`=42, `bout`=0, `busy` high for 8 cycles.
- a=8'h00, b=8'h01, bin=0 -> `diff`=8'hFF, `bout`=1; `ovf`=0 when the macro is defined.
- a=8'h05, b=8'h05, bin=1 -> `diff`=8'hFF, `bout`=1. Then a=8'h80, b=8'h01, bin=0 -> `diff`=8'h7F, `bout`=0, `ovf`=1.
- Start a=8'hF0, b=8'h0F; pulse `start` again with different operands 3 cycles later -> second start ignored; `diff`=8'hE1 after 8 cycles.
- Start any operation; assert `rst` on the 4th RUN cycle -> outputs 0 next cycle, no `done`; a subsequent start of 3-1 yields `diff`=2.
- Random 1000 operands -> every result satisfies `a == diff + b + bin` mod 256 and `bout == (a < b+bin)`; back-to-back starts in DONE yield `done` every 9 cycles.
